// File: rtl/disp_scan_driver.sv
// disp_scan_driver: time-multiplexes an 8-digit hex word onto a common-anode
// 7-segment display, one digit per CLK_DIV-cycle slot. The word and blank
// mask are snapshotted at the digit-0 slot so a frame never shows a mix of
// old and new data.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   EN         scan enable; low darkens the display and restarts the scan
//   DISP_SEQ   eight hex digits, digit i = DISP_SEQ[4i+3:4i], digit 0 rightmost
//   DISP_OFF   bit i = 1 blanks digit i
//   AN         digit anodes, active-low, at most one bit low
//   SEG        segments {g,f,e,d,c,b,a}, active-low
//   FRAME_STB  one-cycle pulse while digit 0 is being driven
module disp_scan_driver #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [31:0] DISP_SEQ,
    input  logic [7:0]  DISP_OFF,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        FRAME_STB
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       ptr;
    logic [31:0]      snap_seq;
    logic [7:0]       snap_off;

    logic        tick_c;
    logic        frame_start_c;
    logic [31:0] cur_seq_c;
    logic [7:0]  cur_off_c;
    logic [3:0]  nib_c;
    logic        blank_c;
    logic [7:0]  an_nxt_c;
    logic [6:0]  seg_nxt_c;

    // Active-low hex to 7-segment decode.
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Slot decode; digit 0 reads the live inputs because the snapshot is
    // being loaded on that same edge.
    always_comb begin
        tick_c        = EN && (cnt == CNT_MAX);
        frame_start_c = (ptr == 3'd0);
        cur_seq_c     = frame_start_c ? DISP_SEQ : snap_seq;
        cur_off_c     = frame_start_c ? DISP_OFF : snap_off;
        nib_c         = cur_seq_c[{ptr, 2'b00} +: 4];
        blank_c       = cur_off_c[ptr];
        an_nxt_c      = blank_c ? 8'hFF : ~(8'd1 << ptr);
        seg_nxt_c     = blank_c ? 7'h7F : hex7(nib_c);
    end

    // Slot prescaler and digit pointer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
            ptr <= 3'd0;
        end else if (!EN) begin
            cnt <= '0;
            ptr <= 3'd0;
        end else if (tick_c) begin
            cnt <= '0;
            ptr <= ptr + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Frame snapshot, retained while EN is low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            snap_seq <= '0;
            snap_off <= 8'hFF;
        end else if (tick_c && frame_start_c) begin
            snap_seq <= DISP_SEQ;
            snap_off <= DISP_OFF;
        end
    end

    // Registered display outputs; hold between ticks.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            AN        <= 8'hFF;
            SEG       <= 7'h7F;
            FRAME_STB <= 1'b0;
        end else if (!EN) begin
            AN        <= 8'hFF;
            SEG       <= 7'h7F;
            FRAME_STB <= 1'b0;
        end else if (tick_c) begin
            AN        <= an_nxt_c;
            SEG       <= seg_nxt_c;
            FRAME_STB <= frame_start_c;
        end else begin
            FRAME_STB <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_scan_driver.sv
// Self-checking bench for disp_scan_driver: table-driven frames, hand-written
// anti-tear / enable / async-reset sequences, then randomized stimulus, all
// checked against a cycle-count based reference model.
module tb_disp_scan_driver;

    localparam int unsigned CLK_DIV = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN  = 1'b1;
    logic [31:0] DISP_SEQ = '0;
    logic [7:0]  DISP_OFF = '0;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        FRAME_STB;

    int n_cmp  = 0;
    int n_fail = 0;

    disp_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .DISP_SEQ  (DISP_SEQ),
        .DISP_OFF  (DISP_OFF),
        .AN        (AN),
        .SEG       (SEG),
        .FRAME_STB (FRAME_STB)
    );

    always #5 CLK = ~CLK;

    logic [6:0] h7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: m_k counts enabled edges since the scan (re)started;
    // every CLK_DIV-th such edge shows digit (k/CLK_DIV - 1) mod 8.
    int          m_k;
    logic [31:0] m_snap_seq;
    logic [7:0]  m_snap_off;
    logic [7:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_stb;

    task automatic model_reset();
        m_k = 0; m_snap_seq = '0; m_snap_off = 8'hFF;
        m_an = 8'hFF; m_seg = 7'h7F; m_stb = 1'b0;
    endtask

    task automatic model_edge();
        int d;
        logic [31:0] sh;
        if (!RST) begin
            model_reset();
        end else if (!EN) begin
            m_k = 0; m_an = 8'hFF; m_seg = 7'h7F; m_stb = 1'b0;
        end else begin
            m_k++;
            if (m_k % CLK_DIV == 0) begin
                d = (m_k / CLK_DIV - 1) % 8;
                if (d == 0) begin
                    m_snap_seq = DISP_SEQ;
                    m_snap_off = DISP_OFF;
                end
                sh = m_snap_seq >> (4 * d);
                if (m_snap_off[d]) begin
                    m_an = 8'hFF; m_seg = 7'h7F;
                end else begin
                    m_an = 8'hFF ^ (8'd1 << d);
                    m_seg = h7[sh[3:0]];
                end
                m_stb = (d == 0);
            end else begin
                m_stb = 1'b0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("an", 32'(AN), 32'(m_an));
        chk("seg", 32'(SEG), 32'(m_seg));
        chk("frame_stb", 32'(FRAME_STB), 32'(m_stb));
        chk("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
    endtask

    // One clock: model sees the same inputs as the DUT edge, compare 1 later.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [31:0] seq;
        logic [7:0]  off;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        stb;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // Two consecutive frames: 8032B032 unblanked, then 0000ABCD with F0.
        tbl[0]  = '{32'h8032B032, 8'h00, 8'hFE, 7'h24, 1'b1};
        tbl[1]  = '{32'h8032B032, 8'h00, 8'hFD, 7'h30, 1'b0};
        tbl[2]  = '{32'h8032B032, 8'h00, 8'hFB, 7'h40, 1'b0};
        tbl[3]  = '{32'h8032B032, 8'h00, 8'hF7, 7'h03, 1'b0};
        tbl[4]  = '{32'h8032B032, 8'h00, 8'hEF, 7'h24, 1'b0};
        tbl[5]  = '{32'h8032B032, 8'h00, 8'hDF, 7'h30, 1'b0};
        tbl[6]  = '{32'h8032B032, 8'h00, 8'hBF, 7'h40, 1'b0};
        tbl[7]  = '{32'h8032B032, 8'h00, 8'h7F, 7'h00, 1'b0};
        tbl[8]  = '{32'h0000ABCD, 8'hF0, 8'hFE, 7'h21, 1'b1};
        tbl[9]  = '{32'h0000ABCD, 8'hF0, 8'hFD, 7'h46, 1'b0};
        tbl[10] = '{32'h0000ABCD, 8'hF0, 8'hFB, 7'h03, 1'b0};
        tbl[11] = '{32'h0000ABCD, 8'hF0, 8'hF7, 7'h08, 1'b0};
        tbl[12] = '{32'h0000ABCD, 8'hF0, 8'hFF, 7'h7F, 1'b0};
        tbl[13] = '{32'h0000ABCD, 8'hF0, 8'hFF, 7'h7F, 1'b0};
        tbl[14] = '{32'h0000ABCD, 8'hF0, 8'hFF, 7'h7F, 1'b0};
        tbl[15] = '{32'h0000ABCD, 8'hF0, 8'hFF, 7'h7F, 1'b0};

        model_reset();

        // Reset held with EN=1: outputs stay dark.
        RST = 1'b0; EN = 1'b1;
        DISP_SEQ = tbl[0].seq; DISP_OFF = tbl[0].off;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_an", 32'(AN), 32'hFF);
            chk("rst_seg", 32'(SEG), 32'h7F);
            chk("rst_stb", 32'(FRAME_STB), 32'h0);
        end
        RST = 1'b1;

        // Table frames; first vector also covers the first-tick latency.
        foreach (tbl[i]) begin
            DISP_SEQ = tbl[i].seq; DISP_OFF = tbl[i].off;
            steps(CLK_DIV);
            chk($sformatf("tbl%0d_an", i), 32'(AN), 32'(tbl[i].an));
            chk($sformatf("tbl%0d_seg", i), 32'(SEG), 32'(tbl[i].seg));
            chk($sformatf("tbl%0d_stb", i), 32'(FRAME_STB), 32'(tbl[i].stb));
        end

        // Anti-tear: change word during slot 3, remaining slots keep old data.
        DISP_SEQ = 32'h11111111; DISP_OFF = 8'h00;
        steps(4 * CLK_DIV);
        DISP_SEQ = 32'h22222222;
        for (int s = 4; s < 8; s++) begin
            steps(CLK_DIV);
            chk($sformatf("tear_old%0d", s), 32'(SEG), 32'h79);
        end
        for (int s = 0; s < 8; s++) begin
            steps(CLK_DIV);
            chk($sformatf("tear_new%0d", s), 32'(SEG), 32'h24);
        end

        // Enable gating: drop EN during slot 5, then restart at digit 0.
        steps(6 * CLK_DIV);
        chk("en_slot5", 32'(AN), 32'hDF);
        EN = 1'b0;
        step();
        chk("en_off_an", 32'(AN), 32'hFF);
        chk("en_off_seg", 32'(SEG), 32'h7F);
        EN = 1'b1;
        steps(CLK_DIV - 1);
        chk("en_wait_an", 32'(AN), 32'hFF);
        step();
        chk("en_restart_an", 32'(AN), 32'hFE);
        chk("en_restart_stb", 32'(FRAME_STB), 32'h1);

        // Async reset between edges during slot 2.
        steps(2 * CLK_DIV);
        chk("ar_slot2", 32'(AN), 32'hFB);
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("ar_an", 32'(AN), 32'hFF);
        steps(2);
        RST = 1'b1;
        DISP_SEQ = 32'h76543210; DISP_OFF = 8'h00;
        steps(CLK_DIV);
        chk("ar_restart_seg", 32'(SEG), 32'h40);

        // Randomized stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) DISP_SEQ = $urandom;
            if ($urandom_range(0, 7) == 0) DISP_OFF = 8'($urandom);
            if ($urandom_range(0, 49) == 0) EN = ~EN;
            else if (!EN && $urandom_range(0, 3) == 0) EN = 1'b1;
            step();
            if ($urandom_range(0, 199) == 0) begin
                RST = 1'b0;
                #1;
                model_reset();
                check_all();
                step();
                RST = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
